// File: rtl/trans_router_n_if.sv
// Bundle for the trans_router_n port set: input side, per-channel outputs, counter readout.
// master: drives init/thresholds/data_in/push/pop/req/idx and observes everything else.
// slave:  the router itself, the reverse direction of master.
interface trans_router_n_if #(
  parameter int DATA_SIZE = 12,
  parameter int CHANNELS  = 4,
  parameter int DEPTH     = 8,
  parameter int CNT_SIZE  = 5
);
  localparam int CH_BITS = $clog2(CHANNELS);
  localparam int TH_SIZE = $clog2(DEPTH) + 1;

  logic                          init;
  logic [TH_SIZE-1:0]            th_almost_full;
  logic [TH_SIZE-1:0]            th_almost_empty;
  logic [DATA_SIZE-1:0]          data_in;
  logic                          push;
  logic [CHANNELS-1:0]           pop;
  logic [CHANNELS*DATA_SIZE-1:0] data_out;
  logic [CHANNELS-1:0]           valid_out;
  logic [CHANNELS-1:0]           full;
  logic [CHANNELS-1:0]           empty;
  logic [CHANNELS-1:0]           almost_full;
  logic [CHANNELS-1:0]           almost_empty;
  logic                          req;
  logic [CH_BITS:0]              idx;
  logic [CNT_SIZE-1:0]           data_out_cont;
  logic                          valid_cont;
  logic [2:0]                    state;
  logic                          idle;
  logic                          error;

  modport master (
    output init, th_almost_full, th_almost_empty, data_in, push, pop, req, idx,
    input  data_out, valid_out, full, empty, almost_full, almost_empty,
           data_out_cont, valid_cont, state, idle, error
  );

  modport slave (
    input  init, th_almost_full, th_almost_empty, data_in, push, pop, req, idx,
    output data_out, valid_out, full, empty, almost_full, almost_empty,
           data_out_cont, valid_cont, state, idle, error
  );
endinterface

// File: rtl/trans_router_n.sv
// Routes each pushed datum to one of CHANNELS FIFOs by its top CH_BITS, with per-channel pop counters.
// Latency: push visible in FIFO next edge; pop data/valid_out and counter readout registered, 1 cycle.
// Backpressure: none upstream; push into a full FIFO without a same-cycle pop drops it and enters ERROR.
// Ports: clk, reset_L (async active-low), bus (trans_router_n_if.slave: push/pop side, flags,
//        per-channel data_out/valid_out, counter readout req/idx -> data_out_cont/valid_cont, state/idle/error).
module trans_router_n #(
  parameter int DATA_SIZE = 12,
  parameter int CHANNELS  = 4,
  parameter int DEPTH     = 8,
  parameter int CNT_SIZE  = 5
) (
  input  logic            clk,
  input  logic            reset_L,
  trans_router_n_if.slave bus
);
  localparam int CH_BITS = $clog2(CHANNELS);
  localparam int TH_SIZE = $clog2(DEPTH) + 1;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int SUM_W   = CNT_SIZE + CH_BITS;
  localparam logic [TH_SIZE-1:0]  FULL_CNT = TH_SIZE'(DEPTH);
  localparam logic [CNT_SIZE-1:0] CNT_MAX  = '1;
  localparam logic [CH_BITS:0]    IDX_SUM  = (CH_BITS+1)'(CHANNELS);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t              r_state;
  logic [DATA_SIZE-1:0] r_mem      [CHANNELS][DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr   [CHANNELS];
  logic [PTR_W-1:0]     r_rd_ptr   [CHANNELS];
  logic [TH_SIZE-1:0]   r_count    [CHANNELS];
  logic [CNT_SIZE-1:0]  r_pop_cnt  [CHANNELS];
  logic [DATA_SIZE-1:0] r_data_out [CHANNELS];
  logic [CHANNELS-1:0]  r_valid_out;
  logic [TH_SIZE-1:0]   r_th_af;
  logic [TH_SIZE-1:0]   r_th_ae;
  logic [CNT_SIZE-1:0]  r_cont;
  logic                 r_valid_cont;
  logic                 r_error;

  logic [CH_BITS-1:0]   w_dest;
  logic                 w_run;
  logic                 w_pop_state;
  logic                 w_flush;
  logic                 w_push_hit;
  logic                 w_overflow;
  logic                 w_any_nxt;
  logic                 w_all_empty;
  logic [CHANNELS-1:0]  w_pop_acc;
  logic [CHANNELS-1:0]  w_push_acc;
  logic [CHANNELS-1:0]  w_full;
  logic [TH_SIZE-1:0]   w_cnt_nxt [CHANNELS];
  logic [SUM_W-1:0]     w_sum;
  logic [CNT_SIZE-1:0]  w_sum_sat;

  // Accept/drop decisions and next-cycle occupancy; init in a running state overrides all traffic.
  always_comb begin
    w_dest      = bus.data_in[DATA_SIZE-1 -: CH_BITS];
    w_run       = (r_state == S_IDLE) || (r_state == S_ACTIVE);
    w_pop_state = w_run || (r_state == S_ERROR);
    w_flush     = bus.init && w_pop_state;
    w_push_hit  = bus.push && w_run && !bus.init;
    w_any_nxt   = 1'b0;
    w_all_empty = 1'b1;
    w_sum       = '0;
    w_pop_acc   = '0;
    w_push_acc  = '0;
    w_full      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_full[i]     = (r_count[i] == FULL_CNT);
      w_pop_acc[i]  = w_pop_state && !bus.init && bus.pop[i] && (r_count[i] != '0);
      // A full channel still takes the push when it is popped in the same cycle.
      w_push_acc[i] = w_push_hit && (w_dest == CH_BITS'(i)) && (!w_full[i] || w_pop_acc[i]);
      w_cnt_nxt[i]  = r_count[i] + TH_SIZE'(w_push_acc[i]) - TH_SIZE'(w_pop_acc[i]);
      w_any_nxt     = w_any_nxt || (w_cnt_nxt[i] != '0);
      w_all_empty   = w_all_empty && (r_count[i] == '0);
      w_sum         = w_sum + SUM_W'(r_pop_cnt[i]);
    end
    w_overflow = w_push_hit && w_full[w_dest] && !w_pop_acc[w_dest];
    w_sum_sat  = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_SIZE-1:0];
  end

  always_comb begin
    bus.data_out     = '0;
    bus.full         = '0;
    bus.empty        = '0;
    bus.almost_full  = '0;
    bus.almost_empty = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.data_out[i*DATA_SIZE +: DATA_SIZE] = r_data_out[i];
      bus.full[i]         = w_full[i];
      bus.empty[i]        = (r_count[i] == '0);
      bus.almost_full[i]  = (r_count[i] >= r_th_af);
      bus.almost_empty[i] = (r_count[i] <= r_th_ae);
    end
  end

  assign bus.valid_out     = r_valid_out;
  assign bus.data_out_cont = r_cont;
  assign bus.valid_cont    = r_valid_cont;
  assign bus.state         = r_state;
  assign bus.error         = r_error;
  assign bus.idle          = (r_state == S_IDLE) && w_all_empty;

  // Storage carries no reset: occupancy counts alone define what is valid.
  always_ff @(posedge clk) begin
    if (|w_push_acc) begin
      r_mem[w_dest][r_wr_ptr[w_dest]] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state      <= S_RESET;
      r_th_af      <= FULL_CNT;
      r_th_ae      <= '0;
      r_error      <= 1'b0;
      r_valid_out  <= '0;
      r_cont       <= '0;
      r_valid_cont <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_count[i]    <= '0;
        r_wr_ptr[i]   <= '0;
        r_rd_ptr[i]   <= '0;
        r_pop_cnt[i]  <= '0;
        r_data_out[i] <= '0;
      end
    end else begin
      // Counter readout: index CHANNELS selects the saturated total, anything above is ignored.
      r_valid_cont <= 1'b0;
      if (bus.req && (bus.idx < IDX_SUM)) begin
        r_cont       <= r_pop_cnt[bus.idx[CH_BITS-1:0]];
        r_valid_cont <= 1'b1;
      end else if (bus.req && (bus.idx == IDX_SUM)) begin
        r_cont       <= w_sum_sat;
        r_valid_cont <= 1'b1;
      end

      if (w_flush) begin
        r_error     <= 1'b0;
        r_valid_out <= '0;
        for (int i = 0; i < CHANNELS; i++) begin
          r_count[i]   <= '0;
          r_wr_ptr[i]  <= '0;
          r_rd_ptr[i]  <= '0;
          r_pop_cnt[i] <= '0;
        end
      end else begin
        for (int i = 0; i < CHANNELS; i++) begin
          r_valid_out[i] <= w_pop_acc[i];
          if (w_pop_acc[i]) begin
            r_data_out[i] <= r_mem[i][r_rd_ptr[i]];
            r_rd_ptr[i]   <= r_rd_ptr[i] + PTR_W'(1);
            if (r_pop_cnt[i] != CNT_MAX) begin
              r_pop_cnt[i] <= r_pop_cnt[i] + CNT_SIZE'(1);
            end
          end
          if (w_push_acc[i]) begin
            r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
          end
          r_count[i] <= w_cnt_nxt[i];
        end
        if (w_overflow) begin
          r_error <= 1'b1;
        end
      end

      case (r_state)
        S_RESET: r_state <= S_INIT;
        S_INIT: begin
          r_th_af <= bus.th_almost_full;
          r_th_ae <= bus.th_almost_empty;
          if (!bus.init) begin
            r_state <= S_IDLE;
          end
        end
        S_IDLE, S_ACTIVE: begin
          if (bus.init) begin
            r_state <= S_INIT;
          end else if (w_overflow) begin
            r_state <= S_ERROR;
          end else begin
            r_state <= w_any_nxt ? S_ACTIVE : S_IDLE;
          end
        end
        S_ERROR: begin
          if (bus.init) begin
            r_state <= S_INIT;
          end
        end
        default: r_state <= S_RESET;
      endcase
    end
  end
endmodule

// File: tb/tb_trans_router_n.sv
module tb_trans_router_n;
  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  trans_router_n_if #(.DATA_SIZE(12), .CHANNELS(4), .DEPTH(8),  .CNT_SIZE(5)) ifa();
  trans_router_n_if #(.DATA_SIZE(12), .CHANNELS(8), .DEPTH(16), .CNT_SIZE(5)) ifb();

  trans_router_n #(.DATA_SIZE(12), .CHANNELS(4), .DEPTH(8), .CNT_SIZE(5)) dut_a (
    .clk(clk), .reset_L(reset_L), .bus(ifa)
  );
  trans_router_n #(.DATA_SIZE(12), .CHANNELS(8), .DEPTH(16), .CNT_SIZE(5)) dut_b (
    .clk(clk), .reset_L(reset_L), .bus(ifb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] dout_a(input int ch);
    return ifa.data_out[ch*12 +: 12];
  endfunction

  function automatic logic [11:0] dout_b(input int ch);
    return ifb.data_out[ch*12 +: 12];
  endfunction

  task automatic push_a(input logic [11:0] d);
    ifa.data_in = d;
    ifa.push    = 1'b1;
    tick();
    ifa.push    = 1'b0;
  endtask

  task automatic pop_a(input int ch);
    ifa.pop = 4'(1 << ch);
    tick();
    ifa.pop = '0;
  endtask

  task automatic read_a(input int idx);
    ifa.req = 1'b1;
    ifa.idx = 3'(idx);
    tick();
    ifa.req = 1'b0;
  endtask

  initial begin
    int k;
    reset_L = 1'b0;
    ifa.init = 1'b1; ifa.th_almost_full = '0; ifa.th_almost_empty = '0;
    ifa.data_in = '0; ifa.push = 1'b0; ifa.pop = '0; ifa.req = 1'b0; ifa.idx = '0;
    ifb.init = 1'b1; ifb.th_almost_full = '0; ifb.th_almost_empty = '0;
    ifb.data_in = '0; ifb.push = 1'b0; ifb.pop = '0; ifb.req = 1'b0; ifb.idx = '0;
    #12;

    // Reset values
    chk("rst_state", ifa.state, 0);
    chk("rst_error", ifa.error, 0);
    chk("rst_idle", ifa.idle, 0);
    chk("rst_valid_out", ifa.valid_out, 0);
    chk("rst_valid_cont", ifa.valid_cont, 0);
    chk("rst_cont", ifa.data_out_cont, 0);
    chk("rst_dout_zero", ifa.data_out == '0, 1);
    chk("rst_empty", ifa.empty, 4'hF);
    chk("rst_full", ifa.full, 0);
    chk("rst_afull", ifa.almost_full, 0);
    chk("rst_aempty", ifa.almost_empty, 4'hF);

    // Configuration: two threshold writes, then leave INIT
    reset_L = 1'b1;
    tick();
    chk("init_state", ifa.state, 1);
    ifa.th_almost_full = 4'd6; ifa.th_almost_empty = 4'd2;
    tick();
    ifa.th_almost_full = 4'd4; ifa.th_almost_empty = 4'd1;
    tick();
    chk("init_hold", ifa.state, 1);
    ifa.init = 1'b0;
    tick();
    chk("idle_state", ifa.state, 2);
    chk("idle_flag", ifa.idle, 1);

    // Channel 0 in-order traffic and thresholds 4/1
    push_a(12'h0F0);
    chk("ae_at_1", ifa.almost_empty, 4'hF);
    push_a(12'h0F1);
    chk("ae_at_2", ifa.almost_empty, 4'hE);
    push_a(12'h0F2);
    chk("af_at_3", ifa.almost_full, 4'h0);
    push_a(12'h0F3);
    chk("af_at_4", ifa.almost_full, 4'h1);
    chk("active_state", ifa.state, 3);
    chk("empty_ch0", ifa.empty, 4'hE);
    chk("active_idle", ifa.idle, 0);
    for (int i = 0; i < 4; i++) begin
      pop_a(0);
      chk("pop0_data", dout_a(0), 12'h0F0 + 12'(i));
      chk("pop0_valid", ifa.valid_out, 4'h1);
    end
    chk("back_idle", ifa.state, 2);
    tick();
    chk("pop0_drop_valid", ifa.valid_out, 0);
    chk("pop0_hold", dout_a(0), 12'h0F3);
    read_a(0);
    chk("cnt0_val", ifa.data_out_cont, 4);
    chk("cnt0_vld", ifa.valid_cont, 1);

    // 30 pops on channel 1 across pointer wrap
    k = 0;
    for (int r = 0; r < 4; r++) begin
      int n;
      n = (r < 3) ? 8 : 6;
      for (int j = 0; j < n; j++) push_a(12'h400 + 12'(k + j));
      for (int j = 0; j < n; j++) begin
        pop_a(1);
        chk("pop1_data", dout_a(1), 12'h400 + 12'(k + j));
      end
      k = k + n;
    end
    read_a(0);
    chk("rd_idx0", ifa.data_out_cont, 4);
    read_a(1);
    chk("rd_idx1", ifa.data_out_cont, 30);
    read_a(2);
    chk("rd_idx2", ifa.data_out_cont, 0);
    read_a(4);
    chk("rd_sum_sat", ifa.data_out_cont, 31);
    chk("rd_sum_vld", ifa.valid_cont, 1);
    read_a(5);
    chk("rd_idx5_vld", ifa.valid_cont, 0);
    chk("rd_idx5_hold", ifa.data_out_cont, 31);

    // Overflow on channel 1
    for (int j = 0; j < 8; j++) push_a(12'h500 + 12'(j));
    chk("ovf_full", ifa.full, 4'h2);
    chk("ovf_noerr", ifa.error, 0);
    push_a(12'h508);
    chk("ovf_error", ifa.error, 1);
    chk("ovf_state", ifa.state, 4);
    for (int j = 0; j < 8; j++) begin
      pop_a(1);
      chk("ovf_pop_data", dout_a(1), 12'h500 + 12'(j));
    end
    chk("ovf_empty", ifa.empty, 4'hF);
    chk("err_stays", ifa.state, 4);
    push_a(12'h011);
    chk("err_push_ign", ifa.empty, 4'hF);
    ifa.init = 1'b1;
    tick();
    chk("reinit_state", ifa.state, 1);
    chk("reinit_error", ifa.error, 0);
    read_a(0);
    chk("flush_cnt0", ifa.data_out_cont, 0);
    read_a(1);
    chk("flush_cnt1", ifa.data_out_cont, 0);
    ifa.init = 1'b0;
    tick();
    chk("reidle", ifa.state, 2);

    // Full channel 2 with simultaneous push/pop, and pop on empty channel 3
    for (int j = 0; j < 8; j++) push_a(12'h800 + 12'(j));
    chk("ch2_full", ifa.full, 4'h4);
    chk("ch2_af", ifa.almost_full, 4'h4);
    ifa.data_in = 12'h8AA; ifa.push = 1'b1; ifa.pop = 4'b1100;
    tick();
    ifa.push = 1'b0; ifa.pop = '0;
    chk("pp_error", ifa.error, 0);
    chk("pp_full", ifa.full, 4'h4);
    chk("pp_valid", ifa.valid_out, 4'h4);
    chk("pp_data2", dout_a(2), 12'h800);
    chk("pp_data3", dout_a(3), 12'h000);
    chk("pp_state", ifa.state, 3);
    for (int j = 1; j < 9; j++) begin
      pop_a(2);
      chk("ch2_drain", dout_a(2), (j < 8) ? 12'h800 + 12'(j) : 12'h8AA);
    end
    chk("ch2_idle", ifa.state, 2);

    // Reset in the middle of traffic discards contents
    push_a(12'h0A1);
    push_a(12'h0A2);
    #3;
    reset_L = 1'b0;
    #1;
    chk("mid_rst_state", ifa.state, 0);
    chk("mid_rst_empty", ifa.empty, 4'hF);
    chk("mid_rst_valid", ifa.valid_out, 0);
    chk("mid_rst_dout", ifa.data_out == '0, 1);
    #1;
    reset_L = 1'b1;
    tick();
    chk("mid_rst_init", ifa.state, 1);
    tick();
    chk("mid_rst_idle", ifa.state, 2);
    pop_a(0);
    chk("mid_rst_nopop", ifa.valid_out, 0);
    chk("mid_rst_nodata", dout_a(0), 0);

    // Eight channels, sixteen deep: routing by top three bits and wrap-around
    ifb.th_almost_full = 5'd16; ifb.th_almost_empty = 5'd0;
    ifb.init = 1'b0;
    tick();
    chk("b_idle", ifb.state, 2);
    for (int j = 0; j < 3; j++) begin
      ifb.data_in = 12'hA00 + 12'(j); ifb.push = 1'b1;
      tick();
    end
    ifb.push = 1'b0;
    chk("b_empty5", ifb.empty, 8'hDF);
    for (int j = 0; j < 20; j++) begin
      ifb.data_in = 12'hA03 + 12'(j); ifb.push = 1'b1; ifb.pop = 8'h20;
      tick();
      chk("b_stream", dout_b(5), 12'hA00 + 12'(j));
    end
    ifb.push = 1'b0;
    for (int j = 20; j < 23; j++) begin
      ifb.pop = 8'h20;
      tick();
      chk("b_tail", dout_b(5), 12'hA00 + 12'(j));
    end
    ifb.pop = '0;
    chk("b_valid", ifb.valid_out, 8'h20);
    chk("b_drained", ifb.empty, 8'hFF);
    chk("b_err", ifb.error, 0);
    ifb.data_in = 12'hE01; ifb.push = 1'b1;
    tick();
    ifb.push = 1'b0;
    chk("b_route7", ifb.empty, 8'h7F);
    chk("b_active", ifb.state, 3);
    ifb.pop = 8'h80;
    tick();
    ifb.pop = '0;
    chk("b_pop7", dout_b(7), 12'hE01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/trans_router_n.md
TRANS_ROUTER_N -- requirements
Module: trans_router_n

Interface
REQ-001 Parameter DATA_SIZE, default 12: datum width; must be at least 4.
REQ-002 Parameter CHANNELS, default 4: output FIFO count; power of 2, 2..16; CH_BITS = log2(CHANNELS).
REQ-003 Parameter DEPTH, default 8: entries per FIFO; power of 2; TH_SIZE = log2(DEPTH)+1.
REQ-004 Parameter CNT_SIZE, default 5: pop-counter width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset_L  in  1  reset, asynchronous, active-low.
REQ-007 init  in  1  enter/stay in configuration state.
REQ-008 th_almost_full, th_almost_empty  in  TH_SIZE each  thresholds, sampled in INIT.
REQ-009 data_in  in  DATA_SIZE  datum; destination = data_in[DATA_SIZE-1 -: CH_BITS].
REQ-010 push  in  1  write data_in to destination FIFO.
REQ-011 pop  in  CHANNELS  per-channel read strobe.
REQ-012 data_out  out  CHANNELS*DATA_SIZE  channel i at bits [i*DATA_SIZE +: DATA_SIZE], registered.
REQ-013 valid_out  out  CHANNELS  data_out slice i valid.
REQ-014 full, empty, almost_full, almost_empty  out  CHANNELS each  per-FIFO flags.
REQ-015 req, idx  in  1, CH_BITS+1  counter readout request and index.
REQ-016 data_out_cont  out  CNT_SIZE  readout value, registered; valid_cont  out  1.
REQ-017 state  out  3  FSM state; idle  out  1; error  out  1.

Function
REQ-018 FSM states SHALL be RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
REQ-019 RESET -> INIT on the first edge after reset_L deasserts.
REQ-020 INIT: thresholds latched every cycle; init=0 -> IDLE.
REQ-021 IDLE -> ACTIVE when any FIFO is non-empty after the edge; ACTIVE -> IDLE when all FIFOs are empty.
REQ-022 From IDLE, ACTIVE or ERROR, init=1 -> INIT on next edge; all FIFOs, counters and error flag are flushed on that edge.
REQ-023 Push is accepted only in IDLE/ACTIVE; the datum is visible in the destination FIFO on the next edge (count+1).
REQ-024 Push to a full FIFO with no same-cycle pop on that channel -> datum dropped, error=1, next state ERROR.
REQ-025 Push and pop on the same full channel in one cycle: both are accepted; the count is unchanged.
REQ-026 Pop on a non-empty FIFO: the head is placed on the data_out slice and valid_out[i]=1 on the next edge; FIFO order preserved.
REQ-027 Pop on an empty FIFO is ignored: valid_out[i]=0, data_out slice holds its value, no error.
REQ-028 Pops are accepted in IDLE, ACTIVE and ERROR; pushes are ignored in ERROR, INIT and RESET.
REQ-029 Flags are combinational from count: full = (count==DEPTH); empty = (count==0); almost_full = (count>=th_almost_full); almost_empty = (count<=th_almost_empty).
REQ-030 Pointers SHALL wrap modulo DEPTH without a bubble.
REQ-031 Per-channel counter increments on each accepted pop and saturates at 2^CNT_SIZE-1.
REQ-032 With req=1 and idx<CHANNELS: next edge data_out_cont=cnt[idx], valid_cont=1.
REQ-033 With req=1 and idx==CHANNELS: next edge data_out_cont = sum of all counters, saturated at 2^CNT_SIZE-1, valid_cont=1.
REQ-034 With req=0 or idx>CHANNELS: valid_cont=0 and data_out_cont holds its value.
REQ-035 idle=1 only when state==IDLE and all FIFOs are empty.

Reset
REQ-036 reset_L=0 SHALL immediately force: state=RESET, all FIFOs empty, pointers 0, counters 0, data_out=0, valid_out=0, data_out_cont=0, valid_cont=0, error=0, idle=0, thresholds = DEPTH (full) and 0 (empty).
REQ-037 Reset asserted mid-transfer discards all contents; no partial datum is emitted afterward.

Verification
REQ-038 Reset with init=1, then release reset; after two thresholds writes (6/2 then 4/1), drop init -> state 1 then 2; thresholds = 4/1.
REQ-039 Push 0x0F0..0x0F3 (defaults) -> FIFO0 count 4, almost_full[0]=1, state=3; pop0 x4 -> data_out ch0 0x0F0..0x0F3 in order, state back to 2, cnt[0]=4.
REQ-040 Push 9 words to channel 1 with DEPTH=8 -> ninth dropped, error=1, state=4; pop1 x8 returns first 8 words; init=1 -> state 1, error=0.
REQ-041 Full channel 2 with simultaneous push and pop2 -> no error, count stays 8; pop on empty channel 3 -> valid_out[3]=0.
REQ-042 After pops 4/0/0/0 and 30 on channel 1 (CNT_SIZE=5): idx=0 -> 4, idx=1 -> 30, idx=4 -> 31 (saturated), idx=5 -> valid_cont=0.
REQ-043 Repeat REQ-039 with CHANNELS=8, DEPTH=16: routing by top 3 bits, wrap-around after 20 push/pop pairs is intact.
